// File: rtl/game_pkg.sv
// Shared maze constants: grid bounds, coordinate widths, direction codes and
// the move scheduler state encoding.
package game_pkg;

    localparam int GRID_X_MAX = 26;
    localparam int GRID_Y_MAX = 23;
    localparam int X_W        = 8;
    localparam int Y_W        = 7;
    localparam int DIR_W      = 3;

    localparam logic [DIR_W-1:0] DIR_RIGHT = 3'b000;
    localparam logic [DIR_W-1:0] DIR_UP    = 3'b001;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 3'b010;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 3'b011;
    localparam logic [DIR_W-1:0] DIR_WAIT  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/step_calc.sv
// Combinational next-cell calculator with tunnel wrap on both axes.
// Unknown direction codes behave as WAIT and return the current cell.
module step_calc
    import game_pkg::*;
#(
    parameter int X_MAX = GRID_X_MAX,
    parameter int Y_MAX = GRID_Y_MAX
) (
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic [DIR_W-1:0] dir,
    output logic [X_W-1:0]   nx,
    output logic [Y_W-1:0]   ny
);

    localparam logic [X_W-1:0] XM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);

    always_comb begin
        nx = x;
        ny = y;
        case (dir)
            DIR_RIGHT: nx = (x == XM) ? '0 : x + X_W'(1);
            DIR_LEFT:  nx = (x == '0) ? XM : x - X_W'(1);
            DIR_UP:    ny = (y == '0) ? YM : y - Y_W'(1);
            DIR_DOWN:  ny = (y == YM) ? '0 : y + Y_W'(1);
            default:   ;
        endcase
    end

endmodule

// File: rtl/move_scheduler.sv
// Per-tick movement sequencer: walks every entity through one shared map
// lookup port, commits non-wall moves and flags Pacman/ghost collisions.
module move_scheduler
    import game_pkg::*;
#(
    parameter int N_ENT = 5,
    parameter int X_MAX = GRID_X_MAX,
    parameter int Y_MAX = GRID_Y_MAX
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic [DIR_W*N_ENT-1:0]   dir_in,
    input  logic [X_W*N_ENT-1:0]     reset_x,
    input  logic [Y_W*N_ENT-1:0]     reset_y,
    output logic [X_W-1:0]           map_x,
    output logic [Y_W-1:0]           map_y,
    input  logic                     map_wall,
    output logic [X_W*N_ENT-1:0]     x_out,
    output logic [Y_W*N_ENT-1:0]     y_out,
    output logic                     busy,
    output logic                     done,
    output logic                     collide,
    output logic                     overrun,
    output logic [1:0]               state_dbg
);

    localparam int IW = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_ENT - 1);

    sched_state_t state, next_state;

    logic [IW-1:0]                   idx;
    logic [N_ENT-1:0][DIR_W-1:0]     dir_q;
    logic [N_ENT-1:0][X_W-1:0]       pos_x;
    logic [N_ENT-1:0][Y_W-1:0]       pos_y;

    logic                            is_last;
    logic                            accept;
    logic                            load_calc;
    logic [IW-1:0]                   calc_idx;
    logic [DIR_W-1:0]                calc_dir;
    logic [X_W-1:0]                  calc_nx;
    logic [Y_W-1:0]                  calc_ny;
    logic                            hit;

    // Handshake: tick is a request and busy is its inverted ready. A tick
    // with busy=0 is accepted that cycle; with busy=1 it is dropped and
    // recorded in the sticky overrun flag.
    assign accept    = (state == S_IDLE) && tick;
    assign is_last   = (idx == LAST_IDX);
    assign load_calc = accept || ((state == S_CHECK) && !is_last);

    // The lookup address is registered on entry to ISSUE, so the address
    // mux points at the entity about to be issued, not the current one.
    always_comb begin
        calc_idx = '0;
        calc_dir = dir_in[DIR_W-1:0];
        if (state == S_CHECK) begin
            calc_idx = is_last ? '0 : idx + IW'(1);
            calc_dir = dir_q[calc_idx];
        end
    end

    step_calc #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_step (
        .x   (pos_x[calc_idx]),
        .y   (pos_y[calc_idx]),
        .dir (calc_dir),
        .nx  (calc_nx),
        .ny  (calc_ny)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (tick) next_state = S_ISSUE;
            end
            S_ISSUE: next_state = S_CHECK;
            S_CHECK: next_state = is_last ? S_DONE : S_ISSUE;
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_x   <= reset_x;
            pos_y   <= reset_y;
            map_x   <= '0;
            map_y   <= '0;
            idx     <= '0;
            dir_q   <= '0;
            overrun <= 1'b0;
        end else begin
            if (tick && (state != S_IDLE)) overrun <= 1'b1;
            if (accept) begin
                dir_q <= dir_in;
                idx   <= '0;
            end
            if (load_calc) begin
                map_x <= calc_nx;
                map_y <= calc_ny;
            end
            // map_x/map_y still hold the target cell for this entity.
            if (state == S_CHECK) begin
                if (!map_wall) begin
                    pos_x[idx] <= map_x;
                    pos_y[idx] <= map_y;
                end
                if (!is_last) idx <= idx + IW'(1);
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int g = 1; g < N_ENT; g++) begin
            if ((pos_x[g] == pos_x[0]) && (pos_y[g] == pos_y[0])) hit = 1'b1;
        end
    end

    assign collide   = (state == S_DONE) && hit;
    assign x_out     = pos_x;
    assign y_out     = pos_y;
    assign state_dbg = state;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a 1-cycle-latency wall map model and
// an end-of-round scoreboard of {collide, x_out, y_out}.
module tb_move_scheduler;

    localparam int N     = 5;
    localparam int SB_W  = 1 + 8*N + 7*N;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             tick = 1'b0;
    logic [3*N-1:0]   dir_in = '0;
    logic [8*N-1:0]   reset_x = '0;
    logic [7*N-1:0]   reset_y = '0;
    logic [7:0]       map_x;
    logic [6:0]       map_y;
    logic             map_wall = 1'b0;
    logic [8*N-1:0]   x_out;
    logic [7*N-1:0]   y_out;
    logic             busy, done, collide, overrun;
    logic [1:0]       state_dbg;

    bit               wall_map [0:26][0:23];
    logic [SB_W-1:0]  exp_q[$];
    logic [7:0]       exp_x [N];
    logic [6:0]       exp_y [N];

    int compared   = 0;
    int mismatched = 0;
    int t_rel      = 0;
    int done_seen  = 0;

    move_scheduler #(.N_ENT(N), .X_MAX(26), .Y_MAX(23)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .dir_in    (dir_in),
        .reset_x   (reset_x),
        .reset_y   (reset_y),
        .map_x     (map_x),
        .map_y     (map_y),
        .map_wall  (map_wall),
        .x_out     (x_out),
        .y_out     (y_out),
        .busy      (busy),
        .done      (done),
        .collide   (collide),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (map_x <= 8'd26 && map_y <= 7'd23) map_wall <= wall_map[map_x][map_y];
        else                                  map_wall <= 1'b1;
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
        t_rel++;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_walls();
        for (int i = 0; i <= 26; i++)
            for (int j = 0; j <= 23; j++) wall_map[i][j] = 1'b0;
    endtask

    task automatic set_rpos(input int i, input logic [7:0] x, input logic [6:0] y);
        reset_x[8*i +: 8] = x;
        reset_y[7*i +: 7] = y;
        exp_x[i] = x;
        exp_y[i] = y;
    endtask

    task automatic set_dir(input int i, input logic [2:0] d);
        dir_in[3*i +: 3] = d;
    endtask

    // Pacman at (px,py), ghosts parked on column 20, everyone WAITing.
    task automatic default_layout(input logic [7:0] px, input logic [6:0] py);
        set_rpos(0, px, py);
        for (int g = 1; g < N; g++) set_rpos(g, 8'd20, 7'(g));
        for (int g = 0; g < N; g++) set_dir(g, 3'b100);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        step();
        step();
        check("rst_busy",    busy,    1'b0);
        check("rst_done",    done,    1'b0);
        check("rst_collide", collide, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_map",     {map_x, map_y}, 15'd0);
        check("rst_pos",     {x_out, y_out}, {reset_x, reset_y});
        reset_n = 1'b1;
        step();
    endtask

    task automatic push_exp(input logic c);
        logic [SB_W-1:0] v;
        v = '0;
        v[SB_W-1] = c;
        for (int i = 0; i < N; i++) begin
            v[7*N + 8*i +: 8] = exp_x[i];
            v[7*i +: 7]       = exp_y[i];
        end
        exp_q.push_back(v);
    endtask

    // Leaves the bench observing cycle T+1 of the new round.
    task automatic start_round();
        tick = 1'b1;
        t_rel = 0;
        step();
        tick = 1'b0;
    endtask

    task automatic finish_round(input string tag);
        logic [SB_W-1:0] e;
        while (done !== 1'b1 && t_rel < 30) step();
        check({tag, "_done_lat"}, t_rel, 11);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            if (done === 1'b1) check({tag, "_result"}, {collide, x_out, y_out}, e);
        end
        step();
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        clear_walls();
        default_layout(8'd5, 7'd5);
        step();
        apply_reset();

        // 1: open floor, Pacman moves right
        set_dir(0, 3'b000);
        exp_x[0] = 8'd6;
        push_exp(1'b0);
        start_round();
        check("t1_busy", busy, 1'b1);
        check("t1_map", {map_x, map_y}, {8'd6, 7'd5});
        step(); step();
        check("t1_pos_t3", {x_out[7:0], y_out[6:0]}, {8'd6, 7'd5});
        finish_round("t1");

        // 2: wall above blocks UP
        clear_walls();
        wall_map[5][4] = 1'b1;
        default_layout(8'd5, 7'd5);
        apply_reset();
        set_dir(0, 3'b001);
        push_exp(1'b0);
        start_round();
        check("t2_map", {map_x, map_y}, {8'd5, 7'd4});
        step(); step();
        check("t2_pos_t3", {x_out[7:0], y_out[6:0]}, {8'd5, 7'd5});
        finish_round("t2");

        // 3: LEFT wraps into open cell, DOWN wraps into a wall
        clear_walls();
        wall_map[3][0] = 1'b1;
        default_layout(8'd0, 7'd10);
        set_rpos(1, 8'd3, 7'd23);
        apply_reset();
        set_dir(0, 3'b010);
        set_dir(1, 3'b011);
        exp_x[0] = 8'd26;
        push_exp(1'b0);
        start_round();
        check("t3_map0", {map_x, map_y}, {8'd26, 7'd10});
        step(); step();
        check("t3_pos0", {x_out[7:0], y_out[6:0]}, {8'd26, 7'd10});
        check("t3_map1", {map_x, map_y}, {8'd3, 7'd0});
        finish_round("t3");

        // 4: Pacman and ghost 2 step into the same cell
        clear_walls();
        default_layout(8'd4, 7'd4);
        set_rpos(2, 8'd6, 7'd4);
        apply_reset();
        set_dir(0, 3'b000);
        set_dir(2, 3'b010);
        exp_x[0] = 8'd5;
        exp_x[2] = 8'd5;
        push_exp(1'b1);
        start_round();
        finish_round("t4");

        // 5: dropped tick sets overrun; tick at T+12 starts a new round
        default_layout(8'd8, 7'd8);
        apply_reset();
        check("t5_ovr_pre", overrun, 1'b0);
        set_dir(0, 3'b011);
        exp_y[0] = 7'd9;
        push_exp(1'b0);
        start_round();
        step(); step(); step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("t5_overrun", overrun, 1'b1);
        finish_round("t5a");
        set_dir(0, 3'b110);
        push_exp(1'b0);
        start_round();
        check("t5_busy_t13", busy, 1'b1);
        finish_round("t5b");
        check("t5_ovr_sticky", overrun, 1'b1);

        // 6: mid-round reset discards the round
        default_layout(8'd10, 7'd10);
        apply_reset();
        set_dir(0, 3'b000);
        start_round();
        step(); step();
        check("t6_pos_t3", x_out[7:0], 8'd11);
        step(); step();
        reset_n = 1'b0;
        step();
        check("t6_rst_pos",  {x_out, y_out}, {reset_x, reset_y});
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_ovr",  overrun, 1'b0);
        check("t6_rst_map",  {map_x, map_y}, 15'd0);
        reset_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        check("t6_no_done", done_seen, 0);
        exp_x[0] = 8'd11;
        push_exp(1'b0);
        start_round();
        finish_round("t6");

        check("sb_drained", exp_q.size(), 0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
